// File: rtl/spi_slave_18bit_pkg.sv
// Shared definitions for the SPI slave.
// Contents:
//   DEFAULT_WORD_W - default word length (18 bits)
//   state_e        - transfer FSM state encoding (IDLE / ACTIVE)
//   mode_cpol()    - clock polarity for an SPI mode number 0..3
//   mode_cpha()    - clock phase for an SPI mode number 0..3
package spi_slave_18bit_pkg;

  localparam int DEFAULT_WORD_W = 18;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Modes 2 and 3 idle with SCLK high.
  function automatic logic mode_cpol(input int mode);
    return (mode >= 2) ? 1'b1 : 1'b0;
  endfunction

  // Modes 1 and 3 sample on the trailing edge.
  function automatic logic mode_cpha(input int mode);
    return ((mode == 1) || (mode == 3)) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input.
// Ports:
//   i_Clk - system clock
//   i_Rst - asynchronous active-high reset, loads RST_VAL into every stage
//   i_D   - asynchronous input
//   o_Q   - synchronized output (STAGES cycles of latency)
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Q
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; the reset value is the line's idle level so no false edge appears after reset.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_D};
    end
  end

  assign o_Q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_18bit.sv
// SPI slave, configurable mode and word length, oversampled by i_Clk.
// Ports:
//   i_Clk, i_Rst                    - system clock, async active-high reset
//   i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI - raw SPI inputs from the master
//   o_SPI_MISO, o_SPI_MISO_En       - serial data out and tristate enable
//   i_TX_Word, i_TX_DV, o_TX_Ready  - transmit holding register interface
//   o_RX_Word, o_RX_DV              - last received word and its valid pulse
//   o_TX_Underrun, o_Frame_Err      - status pulses
module spi_slave_18bit
  import spi_slave_18bit_pkg::*;
#(
  parameter int SPI_MODE         = 0,
  parameter int BIT_PER_TRANSFER = DEFAULT_WORD_W,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_SPI_Clk,
  input  logic                        i_SPI_CS_n,
  input  logic                        i_SPI_MOSI,
  output logic                        o_SPI_MISO,
  output logic                        o_SPI_MISO_En,
  input  logic [BIT_PER_TRANSFER-1:0] i_TX_Word,
  input  logic                        i_TX_DV,
  output logic                        o_TX_Ready,
  output logic [BIT_PER_TRANSFER-1:0] o_RX_Word,
  output logic                        o_RX_DV,
  output logic                        o_TX_Underrun,
  output logic                        o_Frame_Err
);

  localparam logic CPOL  = mode_cpol(SPI_MODE);
  localparam logic CPHA  = mode_cpha(SPI_MODE);
  localparam int   W     = BIT_PER_TRANSFER;
  localparam int   CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
  localparam logic [1:0]       SETTLE_N = 2'(SYNC_STAGES);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic [1:0] settle_q;
  logic armed_q;

  state_e state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0] rx_shift_q, rx_shift_d;
  logic [W-1:0] tx_shift_q, tx_shift_d;
  logic [W-1:0] hold_q, hold_d;
  logic hold_empty_q, hold_empty_d;
  logic [W-1:0] rx_word_q, rx_word_d;
  logic rx_dv_q, rx_dv_d;
  logic underrun_q, underrun_d;
  logic frame_err_q, frame_err_d;
  logic miso_q, miso_d;
  logic load_evt;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_D(i_SPI_Clk), .o_Q(sclk_s)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_D(i_SPI_CS_n), .o_Q(cs_n_s)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_D(i_SPI_MOSI), .o_Q(mosi_s)
  );

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic [W-1:0] load_word;

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  // A CS fall only counts once CS has been seen high after the synchronizer
  // refilled, so a CS held low across reset cannot start a transfer.
  assign cs_fall     = armed_q & cs_prev_q & ~cs_n_s;
  assign cs_rise     = ~cs_prev_q & cs_n_s;
  assign load_word   = hold_empty_q ? '0 : hold_q;

  // Transfer FSM, RX/TX shifting and status pulse generation.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_word_d   = rx_word_q;
    miso_d      = miso_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    load_evt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          load_evt   = 1'b1;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          // CPHA=0 must present the MSb before the first edge; CPHA=1 waits for the leading edge.
          if (CPHA) begin
            tx_shift_d = load_word;
          end else begin
            tx_shift_d = load_word << 1;
            miso_d     = load_word[W-1];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          bit_cnt_d   = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else begin
          if (shift_edge) begin
            miso_d     = tx_shift_q[W-1];
            tx_shift_d = tx_shift_q << 1;
          end else begin
            miso_d = miso_q;
          end
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[W-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              // Word complete: publish it and queue the next TX word unshifted;
              // the next shift edge puts its MSb on MISO.
              bit_cnt_d  = '0;
              rx_word_d  = {rx_shift_q[W-2:0], mosi_s};
              rx_dv_d    = 1'b1;
              load_evt   = 1'b1;
              tx_shift_d = load_word;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
    underrun_d = load_evt & hold_empty_q;
  end

  // Holding register: a new strobe always wins over a simultaneous load, which used the old value.
  always_comb begin
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    if (i_TX_DV) begin
      hold_d       = i_TX_Word;
      hold_empty_d = 1'b0;
    end else if (load_evt) begin
      hold_empty_d = 1'b1;
    end else begin
      hold_empty_d = hold_empty_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sclk_prev_q  <= CPOL;
      cs_prev_q    <= 1'b1;
      settle_q     <= 2'd0;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      rx_word_q    <= '0;
      rx_dv_q      <= 1'b0;
      underrun_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_n_s;
      settle_q     <= (settle_q == SETTLE_N) ? settle_q : settle_q + 2'd1;
      armed_q      <= armed_q | ((settle_q == SETTLE_N) & cs_n_s);
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      rx_word_q    <= rx_word_d;
      rx_dv_q      <= rx_dv_d;
      underrun_q   <= underrun_d;
      frame_err_q  <= frame_err_d;
      miso_q       <= miso_d;
    end
  end

  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = ~cs_n_s;
  assign o_TX_Ready    = hold_empty_q;
  assign o_RX_Word     = rx_word_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_TX_Underrun = underrun_q;
  assign o_Frame_Err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_18bit.sv
// Bench for spi_slave_18bit: one instance per SPI mode, a bit-banged master,
// and a word-level model of the holding register and expected traffic.
module tb_spi_slave_18bit;

  localparam int W    = 18;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] sclk, cs_n, tx_dv;
  logic [3:0] miso, miso_en, tx_ready, rx_dv, underrun, ferr;
  logic mosi;
  logic [W-1:0] tx_word;
  logic [W-1:0] rx_word [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_18bit #(
      .SPI_MODE(g), .BIT_PER_TRANSFER(W), .SYNC_STAGES((g == 3) ? 3 : 2)
    ) u_dut (
      .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sclk[g]), .i_SPI_CS_n(cs_n[g]),
      .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[g]), .o_SPI_MISO_En(miso_en[g]),
      .i_TX_Word(tx_word), .i_TX_DV(tx_dv[g]), .o_TX_Ready(tx_ready[g]),
      .o_RX_Word(rx_word[g]), .o_RX_DV(rx_dv[g]), .o_TX_Underrun(underrun[g]),
      .o_Frame_Err(ferr[g])
    );
  end

  // Pulse monitor: counts high cycles of each status pulse and logs received words.
  int n_rxdv [4] = '{0, 0, 0, 0};
  int n_unr  [4] = '{0, 0, 0, 0};
  int n_ferr [4] = '{0, 0, 0, 0};
  logic [W-1:0] rx_log [4][16];

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m]) begin
        rx_log[m][n_rxdv[m] % 16] <= rx_word[m];
        n_rxdv[m] <= n_rxdv[m] + 1;
      end
      if (underrun[m]) n_unr[m] <= n_unr[m] + 1;
      if (ferr[m]) n_ferr[m] <= n_ferr[m] + 1;
    end
  end

  // Reference model state
  logic [W-1:0] m_hold [4];
  bit           m_full [4];
  logic [W-1:0] m_last_rx [4];
  logic [W-1:0] mosi_w [8];
  logic [W-1:0] reload_w [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_load(input int m, input logic [W-1:0] w);
    tx_word   = w;
    tx_dv[m]  = 1'b1;
    @(negedge clk);
    tx_dv[m]  = 1'b0;
    m_hold[m] = w;
    m_full[m] = 1'b1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_full[m]    = 1'b0;
      m_hold[m]    = '0;
      m_last_rx[m] = '0;
    end
  endtask

  // One CS-low frame of nbits on instance m, reloading the holding register n_reload times.
  task automatic spi_frame(input int m, input int nbits, input int n_reload);
    logic cpol, cpha;
    logic [W-1:0] exp_tx [8];
    logic [W-1:0] rd;
    int exp_unr, nwords, nrel, rdv0, unr0, fe0, w, b;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    exp_unr = 0; nrel = 0; rd = '0;
    nwords = nbits / W;
    rdv0 = n_rxdv[m]; unr0 = n_unr[m]; fe0 = n_ferr[m];
    exp_tx[0] = m_full[m] ? m_hold[m] : '0;
    if (!m_full[m]) exp_unr++;
    m_full[m] = 1'b0;
    cs_n[m] = 1'b0;
    if (!cpha) mosi = mosi_w[0][W-1];
    cycles(HALF);
    check_eq($sformatf("miso_en_active m%0d", m), miso_en[m], 1);
    check_eq($sformatf("tx_ready_after_load m%0d", m), tx_ready[m], !m_full[m]);
    for (int i = 0; i < nbits; i++) begin
      w = i / W;
      b = W - 1 - (i % W);
      sclk[m] = ~cpol;
      if (!cpha) rd[b] = miso[m];
      else mosi = mosi_w[w][b];
      cycles(HALF);
      sclk[m] = cpol;
      if (cpha) rd[b] = miso[m];
      else if (i + 1 < nbits) mosi = mosi_w[(i + 1) / W][W - 1 - ((i + 1) % W)];
      if (b == 0) begin
        check_eq($sformatf("miso_word m%0d w%0d", m, w), rd, exp_tx[w]);
        exp_tx[w + 1] = m_full[m] ? m_hold[m] : '0;
        if (!m_full[m]) exp_unr++;
        m_full[m] = 1'b0;
      end
      cycles(HALF);
      if ((b == W - 3) && (nrel < n_reload)) begin
        check_eq($sformatf("tx_ready_reload m%0d", m), tx_ready[m], !m_full[m]);
        tx_load(m, reload_w[nrel]);
        nrel++;
      end
    end
    cs_n[m] = 1'b1;
    cycles(HALF);
    check_eq($sformatf("rx_dv_count m%0d", m), n_rxdv[m] - rdv0, nwords);
    for (int k = 0; k < nwords; k++) begin
      check_eq($sformatf("rx_word m%0d w%0d", m, k), rx_log[m][(rdv0 + k) % 16], mosi_w[k]);
      m_last_rx[m] = mosi_w[k];
    end
    check_eq($sformatf("rx_word_hold m%0d", m), rx_word[m], m_last_rx[m]);
    check_eq($sformatf("underrun_count m%0d", m), n_unr[m] - unr0, exp_unr);
    check_eq($sformatf("frame_err_count m%0d", m), n_ferr[m] - fe0, (nbits % W) != 0);
    check_eq($sformatf("miso_idle m%0d", m), {miso_en[m], miso[m]}, 2'b00);
  endtask

  int rdv0, unr0, fe0;

  initial begin
    rst = 1'b1; cs_n = 4'hF; sclk = 4'b1100; tx_dv = 4'h0; mosi = 1'b0; tx_word = '0;
    model_reset();
    cycles(3);
    rst = 1'b0;
    cycles(4);
    check_eq("reset_tx_ready", tx_ready, 4'hF);
    check_eq("reset_miso", {miso_en, miso}, 8'h00);
    check_eq("reset_pulses", {rx_dv, underrun, ferr}, 12'h000);
    for (int m = 0; m < 4; m++) check_eq($sformatf("reset_rx_word m%0d", m), rx_word[m], 0);

    // Mode 0 directed word, with an overwritten holding value first
    tx_load(0, W'($urandom));
    tx_load(0, 18'h2A5A5);
    mosi_w[0] = 18'h15A5A;
    spi_frame(0, W, 0);

    // Modes 1..3: all-ones in, 0x00001 out
    for (int m = 1; m < 4; m++) begin
      tx_load(m, 18'h00001);
      mosi_w[0] = 18'h3FFFF;
      spi_frame(m, W, 0);
    end

    // Three-word burst, holding reloaded after every load
    tx_load(0, W'($urandom));
    for (int k = 0; k < 3; k++) begin
      mosi_w[k]   = W'($urandom);
      reload_w[k] = W'($urandom);
    end
    spi_frame(0, 3 * W, 3);

    // Aborted frame after 9 bits, then a clean frame
    mosi_w[0] = W'($urandom);
    spi_frame(0, 9, 0);
    tx_load(0, W'($urandom));
    mosi_w[0] = W'($urandom);
    spi_frame(0, W, 0);

    // Empty holding register at CS fall
    mosi_w[0] = W'($urandom);
    spi_frame(2, W, 0);

    // Reset in the middle of bit 5
    tx_load(0, W'($urandom));
    cs_n[0] = 1'b0;
    mosi = 1'b1;
    cycles(HALF);
    for (int i = 0; i < 5; i++) begin
      sclk[0] = 1'b1; cycles(HALF);
      sclk[0] = 1'b0; mosi = ~mosi; cycles(HALF);
    end
    sclk[0] = 1'b1;
    cycles(3);
    #2 rst = 1'b1;
    #1;
    check_eq("midreset_tx_ready", tx_ready, 4'hF);
    check_eq("midreset_miso", {miso_en, miso}, 8'h00);
    check_eq("midreset_pulses", {rx_dv, underrun, ferr}, 12'h000);
    check_eq("midreset_rx_word", rx_word[0], 0);
    model_reset();
    cycles(3);
    rst = 1'b0;
    rdv0 = n_rxdv[0]; unr0 = n_unr[0]; fe0 = n_ferr[0];
    for (int i = 0; i < 5; i++) begin
      cycles(HALF); sclk[0] = 1'b0;
      cycles(HALF); sclk[0] = 1'b1;
    end
    cycles(HALF);
    sclk[0] = 1'b0;
    check_eq("postreset_miso", miso[0], 0);
    cs_n[0] = 1'b1;
    cycles(2 * HALF);
    check_eq("postreset_no_start", {n_rxdv[0] - rdv0, n_unr[0] - unr0, n_ferr[0] - fe0}, 0);
    tx_load(0, W'($urandom));
    mosi_w[0] = 18'h12345;
    spi_frame(0, W, 0);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      int m, nw, nb;
      m  = $urandom_range(0, 3);
      nw = $urandom_range(1, 3);
      nb = nw * W;
      if ($urandom_range(0, 3) == 0) nb = nb + $urandom_range(1, W - 1);
      if ($urandom_range(0, 1) == 1) tx_load(m, W'($urandom));
      for (int k = 0; k < 4; k++) begin
        mosi_w[k]   = W'($urandom);
        reload_w[k] = W'($urandom);
      end
      spi_frame(m, nb, $urandom_range(0, nw));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
